// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 5-stage pipeline: widths, the NOP
// encoding, opcodes, instruction field positions and the fetch FSM states.
package cpu_pkg;

    localparam int XLEN = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_LW  = 4'h8,
        OP_SW  = 4'h9,
        OP_BEQ = 4'hC,
        OP_JMP = 4'hD,
        OP_HLT = 4'hF
    } opcode_t;

    // Instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        DISCARD  = 2'd2,
        HALT     = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. load captures a fetched instruction, bubble
// replaces the slot with a NOP (pc2 is kept), neither holds the contents.
// Rs/Rt are masked to zero whenever the slot does not hold a real instruction.
module ifid_reg #(
    parameter int          XLEN      = 16,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc2_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc2,
    output logic [3:0]      rs,
    output logic [3:0]      rt
);
    import cpu_pkg::*;

    // Register update: load wins over bubble, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR[XLEN-1:0];
            pc2   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc2   <= pc2_in;
        end else if (bubble) begin
            valid <= 1'b0;
            instr <= NOP_INSTR[XLEN-1:0];
        end
    end

    assign rs = valid ? instr[RS_MSB:RS_LSB] : 4'd0;
    assign rt = valid ? instr[RT_MSB:RT_LSB] : 4'd0;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID register. Handles a variable-latency
// instruction memory, load-use stalls, branch flushes and HLT.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module if_fetch_stage #(
    parameter int          XLEN       = 16,
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            imem_ready_i,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic [XLEN-1:0] ifid_pc2_o,
    output logic [3:0]      ifid_rs_o,
    output logic [3:0]      ifid_rt_o,
    output logic            fetch_halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles_o,
    output logic [31:0]     flush_count_o
`endif
);
    import cpu_pkg::*;

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] discard_addr_reg, discard_addr_next;
    logic            req;
    logic            load;
    logic            bubble;
    logic [XLEN-1:0] pc_plus2;
    logic            is_hlt;

    assign pc_plus2 = pc_reg + XLEN'(2);
    assign is_hlt   = (imem_rdata_i[XLEN-1 -: 4] == HLT_OPCODE);

    // State, PC and the address of an in-flight request being discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= RUN;
            pc_reg           <= RESET_PC[XLEN-1:0];
            discard_addr_reg <= '0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            discard_addr_reg <= discard_addr_next;
        end
    end

    // Next-state, PC and IF/ID control; priority is flush > stall > memory
    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        discard_addr_next = discard_addr_reg;
        load              = 1'b0;
        bubble            = 1'b0;
        req               = 1'b0;

        case (state_reg)
            RUN:      req = !stall_i;
            WAIT_MEM: req = 1'b1;
            DISCARD:  req = 1'b1;
            default:  req = 1'b0;
        endcase

        if (flush_i) begin
            bubble  = 1'b1;
            // Instructions are halfword aligned: the target LSB is forced low
            pc_next = redirect_pc_i & ~XLEN'(1);
            case (state_reg)
                WAIT_MEM: begin
                    // The outstanding read cannot be cancelled; wait it out
                    if (!imem_ready_i) begin
                        state_next        = DISCARD;
                        discard_addr_next = pc_reg;
                    end else begin
                        state_next = RUN;
                    end
                end
                DISCARD: begin
                    if (imem_ready_i) state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end else if (stall_i) begin
            // IF/ID and PC hold; a discarded response may still retire
            if (state_reg == DISCARD && imem_ready_i) state_next = RUN;
        end else begin
            case (state_reg)
                RUN, WAIT_MEM: begin
                    if (imem_ready_i) begin
                        load       = 1'b1;
                        pc_next    = pc_plus2;
                        state_next = is_hlt ? HALT : RUN;
                    end else begin
                        bubble     = 1'b1;
                        state_next = WAIT_MEM;
                    end
                end
                DISCARD: begin
                    bubble = 1'b1;
                    if (imem_ready_i) state_next = RUN;
                end
                default: bubble = 1'b1;
            endcase
        end
    end

    // No request may appear on the bus while reset is asserted
    assign imem_req_o     = rst_n & req;
    assign imem_addr_o    = (state_reg == DISCARD) ? discard_addr_reg : pc_reg;
    assign fetch_halted_o = (state_reg == HALT);

    ifid_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .bubble   (bubble),
        .instr_in (imem_rdata_i),
        .pc2_in   (pc_plus2),
        .valid    (ifid_valid_o),
        .instr    (ifid_instr_o),
        .pc2      (ifid_pc2_o),
        .rs       (ifid_rs_o),
        .rt       (ifid_rt_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Saturating counters of stalled cycles and flush cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_i && !flush_i && stall_cnt_reg != 32'hFFFF_FFFF)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (flush_i && flush_cnt_reg != 32'hFFFF_FFFF)
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_reg;
    assign flush_count_o  = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage. Memory model returns mem[a]=a,
// except address 0x000A returns 0xF000 (HLT) once hlt_mem is set.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic [15:0] redirect_pc_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_rdata_i;
    logic        imem_ready_i;
    logic        ifid_valid_o;
    logic [15:0] ifid_instr_o;
    logic [15:0] ifid_pc2_o;
    logic [3:0]  ifid_rs_o;
    logic [3:0]  ifid_rt_o;
    logic        fetch_halted_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_count_o;
`endif

    logic hlt_mem;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always_comb imem_rdata_i = (hlt_mem && imem_addr_o == 16'h000A) ? 16'hF000 : imem_addr_o;

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .redirect_pc_i  (redirect_pc_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_rdata_i   (imem_rdata_i),
        .imem_ready_i   (imem_ready_i),
        .ifid_valid_o   (ifid_valid_o),
        .ifid_instr_o   (ifid_instr_o),
        .ifid_pc2_o     (ifid_pc2_o),
        .ifid_rs_o      (ifid_rs_o),
        .ifid_rt_o      (ifid_rt_o),
        .fetch_halted_o (fetch_halted_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        redirect_pc_i = 16'h0000; imem_ready_i = 1'b1; hlt_mem = 1'b0;

        // Reset state
        step(); step();
        check("rst_req",    32'(imem_req_o), 32'h0);
        check("rst_valid",  32'(ifid_valid_o), 32'h0);
        check("rst_instr",  32'(ifid_instr_o), 32'h0);
        check("rst_pc2",    32'(ifid_pc2_o), 32'h0);
        check("rst_halted", 32'(fetch_halted_o), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_addr0",  32'(imem_addr_o), 32'h0000);
        check("rel_req",    32'(imem_req_o), 32'h1);

        // Sequential fetch with ready tied high
        step();
        check("f1_valid", 32'(ifid_valid_o), 32'h1);
        check("f1_instr", 32'(ifid_instr_o), 32'h0000);
        check("f1_pc2",   32'(ifid_pc2_o), 32'h0002);
        check("f1_addr",  32'(imem_addr_o), 32'h0002);
        step();
        check("f2_addr",  32'(imem_addr_o), 32'h0004);
        step();
        check("f3_instr", 32'(ifid_instr_o), 32'h0004);
        check("f3_rt",    32'(ifid_rt_o), 32'h4);

        // Two stall cycles hold IF/ID and PC with no request
        stall_i = 1'b1;
        #1;
        check("stall_req", 32'(imem_req_o), 32'h0);
        step();
        check("st1_instr", 32'(ifid_instr_o), 32'h0004);
        check("st1_addr",  32'(imem_addr_o), 32'h0006);
        step();
        check("st2_instr", 32'(ifid_instr_o), 32'h0004);
        check("st2_pc2",   32'(ifid_pc2_o), 32'h0006);
        stall_i = 1'b0;
        #1;
        check("rel_addr6", 32'(imem_addr_o), 32'h0006);
        step();
        check("f6_instr",  32'(ifid_instr_o), 32'h0006);

        // Flush beats stall; redirect LSB cleared
        stall_i = 1'b1; flush_i = 1'b1; redirect_pc_i = 16'h0041;
        step();
        check("fl_valid", 32'(ifid_valid_o), 32'h0);
        check("fl_rs",    32'(ifid_rs_o), 32'h0);
        check("fl_rt",    32'(ifid_rt_o), 32'h0);
        check("fl_pc2",   32'(ifid_pc2_o), 32'h0008);
        check("fl_addr",  32'(imem_addr_o), 32'h0040);

        // Redirect to 0x0010, then a slow memory with a flush in its shadow
        stall_i = 1'b0; redirect_pc_i = 16'h0010;
        step();
        flush_i = 1'b0; imem_ready_i = 1'b0;
        step();
        check("wm_req",   32'(imem_req_o), 32'h1);
        check("wm_addr",  32'(imem_addr_o), 32'h0010);
        flush_i = 1'b1; redirect_pc_i = 16'h0100;
        step();
        flush_i = 1'b0;
        check("dc_addr",  32'(imem_addr_o), 32'h0010);
        check("dc_req",   32'(imem_req_o), 32'h1);
        step();
        check("dc2_addr", 32'(imem_addr_o), 32'h0010);
        imem_ready_i = 1'b1;
        step();
        check("dc_valid", 32'(ifid_valid_o), 32'h0);
        check("rd_addr",  32'(imem_addr_o), 32'h0100);
        step();
        check("rd_instr", 32'(ifid_instr_o), 32'h0100);
        check("rd_pc2",   32'(ifid_pc2_o), 32'h0102);

        // HLT at 0x000A halts fetch until a flush
        flush_i = 1'b1; redirect_pc_i = 16'h000A;
        step();
        flush_i = 1'b0; hlt_mem = 1'b1;
        check("h_addr",   32'(imem_addr_o), 32'h000A);
        step();
        check("h_valid",  32'(ifid_valid_o), 32'h1);
        check("h_instr",  32'(ifid_instr_o), 32'hF000);
        check("h_pc2",    32'(ifid_pc2_o), 32'h000C);
        check("h_halted", 32'(fetch_halted_o), 32'h1);
        check("h_req",    32'(imem_req_o), 32'h0);
        step();
        check("h2_valid", 32'(ifid_valid_o), 32'h0);
        check("h2_addr",  32'(imem_addr_o), 32'h000C);
        check("h2_halt",  32'(fetch_halted_o), 32'h1);
        flush_i = 1'b1; redirect_pc_i = 16'h0020;
        step();
        check("hx_halt",  32'(fetch_halted_o), 32'h0);
        check("hx_addr",  32'(imem_addr_o), 32'h0020);
        check("hx_req",   32'(imem_req_o), 32'h1);

        // PC wrap at 0xFFFE
        redirect_pc_i = 16'hFFFE;
        step();
        flush_i = 1'b0;
        check("w_addr",   32'(imem_addr_o), 32'hFFFE);
        step();
        check("w_instr",  32'(ifid_instr_o), 32'hFFFE);
        check("w_pc2",    32'(ifid_pc2_o), 32'h0000);
        check("w_addr0",  32'(imem_addr_o), 32'h0000);

`ifdef FETCH_PERF_CNT_EN
        // Counters from a fresh reset: 3 stall cycles, 2 flush cycles
        rst_n = 1'b0;
        step();
        check("pc_rst", stall_cycles_o, 32'd0);
        rst_n = 1'b1; stall_i = 1'b1;
        step(); step(); step();
        stall_i = 1'b0; flush_i = 1'b1; redirect_pc_i = 16'h0000;
        step(); step();
        flush_i = 1'b0;
        step();
        check("pc_stall", stall_cycles_o, 32'd3);
        check("pc_flush", flush_count_o, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
